// File: rtl/rs_gf_pkg.sv
// Shared GF(256) definitions for the RS(6,2) decoder: field constants, symbol type,
// Chien search FSM states and constant-multiply helper.
package rs_gf_pkg;

    localparam logic [8:0] GF_POLY    = 9'h11D;
    localparam logic [7:0] ALPHA_INV1 = 8'h8E;
    localparam logic [7:0] ALPHA_INV2 = 8'h47;
    localparam logic [7:0] ALPHA_INV3 = 8'hAD;
    localparam int         N_SYM      = 6;

    typedef logic [7:0] gf_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FINISH
    } state_t;

    // Shift-and-add multiply; with one operand constant this folds to an XOR network.
    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t p;
        gf_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [1:0] deg_of(input gf_t c1, input gf_t c2, input gf_t c3);
        if (c3 != '0)      return 2'd3;
        else if (c2 != '0) return 2'd2;
        else if (c1 != '0) return 2'd1;
        else               return 2'd0;
    endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Combinational GF(256) multiply of a symbol by a fixed constant CONST.
module rs_gf_cmul
    import rs_gf_pkg::*;
#(
    parameter gf_t CONST = 8'h01
) (
    input  gf_t a,
    output gf_t y
);

    assign y = gf_mul(a, CONST);

endmodule

// File: rtl/rs_chien_search.sv
// Sequential Chien search over N positions of the RS(6,2) codeword, one position per clock.
// Optional macro CHIEN_EARLY_EXIT_EN stops the search once err_cnt reaches deg (deg > 0).
module rs_chien_search
    import rs_gf_pkg::*;
#(
    parameter int N = N_SYM
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   s0,
    input  logic [7:0]   s1,
    input  logic [7:0]   s2,
    input  logic [7:0]   s3,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] err_mask,
    output logic [2:0]   err_cnt,
    output logic [1:0]   deg,
    output logic         fail
);

    state_t       state, state_nxt;
    gf_t          r0, r1, r2, r3;
    gf_t          m1, m2, m3;
    gf_t          eval;
    logic [N-1:0] pos;
    logic         eval_zero;
    logic         stop;
    logic [2:0]   cnt_inc;

    rs_gf_cmul #(.CONST(ALPHA_INV1)) u_mul1 (.a(r1), .y(m1));
    rs_gf_cmul #(.CONST(ALPHA_INV2)) u_mul2 (.a(r2), .y(m2));
    rs_gf_cmul #(.CONST(ALPHA_INV3)) u_mul3 (.a(r3), .y(m3));

    // Term k holds s_k * alpha^(-k*j), so the XOR of all terms is sigma(alpha^-j).
    assign eval      = r0 ^ r1 ^ r2 ^ r3;
    assign eval_zero = (eval == '0);
    assign cnt_inc   = (err_cnt == 3'd7) ? 3'd7 : err_cnt + 3'd1;

`ifdef CHIEN_EARLY_EXIT_EN
    assign stop = pos[N-1] || (eval_zero && (deg != 2'd0) && (cnt_inc == {1'b0, deg}));
`else
    assign stop = pos[N-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEARCH;
            SEARCH:  if (stop)  state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0       <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            pos      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_mask <= '0;
            err_cnt  <= '0;
            deg      <= '0;
            fail     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r0       <= s0;
                        r1       <= s1;
                        r2       <= s2;
                        r3       <= s3;
                        deg      <= deg_of(s1, s2, s3);
                        err_mask <= '0;
                        err_cnt  <= '0;
                        pos      <= N'(1);
                        busy     <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (eval_zero) begin
                        err_mask <= err_mask | pos;
                        err_cnt  <= cnt_inc;
                    end
                    r1  <= m1;
                    r2  <= m2;
                    r3  <= m3;
                    pos <= pos << 1;
                end
                FINISH: begin
                    fail <= (r0 == '0) || (err_cnt != {1'b0, deg});
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_chien_search.sv
// Directed self-checking bench for rs_chien_search (default build, N=6).
module tb_rs_chien_search;

    localparam int N = 6;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   s0, s1, s2, s3;
    logic         busy, done, fail;
    logic [N-1:0] err_mask;
    logic [2:0]   err_cnt;
    logic [1:0]   deg;

    int checks;
    int failures;

    rs_chien_search #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .busy     (busy),
        .done     (done),
        .err_mask (err_mask),
        .err_cnt  (err_cnt),
        .deg      (deg),
        .fail     (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start with the given sigma and counts edges after the sampling edge until done
    // (-1 on timeout). At edge count 'inject' a second start with an out-of-range locator is pulsed.
    task automatic run_search(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input int inject, output int lat);
        @(posedge clk); #1;
        s0 = c0; s1 = c1; s2 = c2; s3 = c3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == inject) begin
                s0 = 8'h01; s1 = 8'h74; s2 = 8'h00; s3 = 8'h00;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, fail, err_mask, err_cnt, deg} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b fail=%b mask=%b cnt=%0d deg=%0d, need all 0",
                     busy, done, fail, err_mask, err_cnt, deg);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_error;
        int lat;
        run_search(8'h01, 8'h00, 8'h00, 8'h00, 0, lat);
        checks++;
        if (lat !== N + 1) begin
            failures++; $display("FAIL no_error_latency: got %0d edges, need %0d", lat, N + 1);
        end
        checks++;
        if ({err_mask, err_cnt, deg, fail} !== {6'b000000, 3'd0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL no_error_result: got mask=%b cnt=%0d deg=%0d fail=%b, need 000000/0/0/0",
                     err_mask, err_cnt, deg, fail);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++; $display("FAIL done_pulse_width: got done=%b busy=%b, need 0/0", done, busy);
        end
        checks++;
        if (err_mask !== 6'b000000 || fail !== 1'b0) begin
            failures++; $display("FAIL result_hold: got mask=%b fail=%b, need 000000/0", err_mask, fail);
        end
    endtask

    task automatic test_single_error;
        int lat;
        run_search(8'h01, 8'h04, 8'h00, 8'h00, 0, lat);
        checks++;
        if (lat !== N + 1) begin
            failures++; $display("FAIL single_latency: got %0d edges, need %0d", lat, N + 1);
        end
        checks++;
        if ({err_mask, err_cnt, deg, fail} !== {6'b000100, 3'd1, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_result: got mask=%b cnt=%0d deg=%0d fail=%b, need 000100/1/1/0",
                     err_mask, err_cnt, deg, fail);
        end
    endtask

    task automatic test_double_error;
        int lat;
        run_search(8'h01, 8'h09, 8'h08, 8'h00, 0, lat);
        checks++;
`ifdef CHIEN_EARLY_EXIT_EN
        // Last root is at position 3 (4th evaluation), so done follows one FINISH edge later.
        if (lat !== 5) begin
            failures++; $display("FAIL double_latency: got %0d edges, need 5", lat);
        end
`else
        if (lat !== N + 1) begin
            failures++; $display("FAIL double_latency: got %0d edges, need %0d", lat, N + 1);
        end
`endif
        checks++;
        if ({err_mask, err_cnt, deg, fail} !== {6'b001001, 3'd2, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL double_result: got mask=%b cnt=%0d deg=%0d fail=%b, need 001001/2/2/0",
                     err_mask, err_cnt, deg, fail);
        end
    endtask

    task automatic test_out_of_range;
        int lat;
        run_search(8'h01, 8'h74, 8'h00, 8'h00, 0, lat);
        checks++;
        if (lat !== N + 1 || {err_mask, err_cnt, deg, fail} !== {6'b000000, 3'd0, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL out_of_range: got lat=%0d mask=%b cnt=%0d deg=%0d fail=%b, need %0d/000000/0/1/1",
                     lat, err_mask, err_cnt, deg, fail, N + 1);
        end
    endtask

    task automatic test_all_zero;
        int lat;
        run_search(8'h00, 8'h00, 8'h00, 8'h00, 0, lat);
        checks++;
        if (lat !== N + 1 || {err_mask, err_cnt, deg, fail} !== {6'b111111, 3'd6, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL all_zero: got lat=%0d mask=%b cnt=%0d deg=%0d fail=%b, need %0d/111111/6/0/1",
                     lat, err_mask, err_cnt, deg, fail, N + 1);
        end
    endtask

    task automatic test_restart_ignored;
        int lat;
        run_search(8'h01, 8'h04, 8'h00, 8'h00, 3, lat);
        checks++;
        if (lat !== N + 1 || {err_mask, err_cnt, deg, fail} !== {6'b000100, 3'd1, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL restart_ignored: got lat=%0d mask=%b cnt=%0d deg=%0d fail=%b, need %0d/000100/1/1/0",
                     lat, err_mask, err_cnt, deg, fail, N + 1);
        end
        // The ignored pulse must not launch a second search afterwards.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || err_mask !== 6'b000100) begin
            failures++; $display("FAIL restart_no_relaunch: got busy=%b mask=%b, need 0/000100", busy, err_mask);
        end
    endtask

    task automatic test_reset_mid_search;
        int  lat;
        bit  done_seen;
        @(posedge clk); #1;
        s0 = 8'h01; s1 = 8'h04; s2 = 8'h00; s3 = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_during_search: got %b, need 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, fail, err_mask, err_cnt, deg} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs: got busy=%b done=%b fail=%b mask=%b cnt=%0d deg=%0d, need all 0",
                     busy, done, fail, err_mask, err_cnt, deg);
        end
        done_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            failures++; $display("FAIL aborted_no_done: got done_seen=%b, need 0", done_seen);
        end
        run_search(8'h01, 8'h04, 8'h00, 8'h00, 0, lat);
        checks++;
        if (lat !== N + 1 || {err_mask, err_cnt, deg, fail} !== {6'b000100, 3'd1, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL after_reset_search: got lat=%0d mask=%b cnt=%0d deg=%0d fail=%b, need %0d/000100/1/1/0",
                     lat, err_mask, err_cnt, deg, fail, N + 1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_no_error();
        test_single_error();
        test_double_error();
        test_out_of_range();
        test_all_zero();
        test_restart_ignored();
        test_reset_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
